// File: rtl/cache_refill_ctrl.sv
// Round-robin cache-line refill / write-back engine sharing one pipelined memory port.
// Define CACHE_REFILL_CWF_EN to issue and write refills critical-word-first.
module cache_refill_ctrl #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned LINE_WORDS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    req_change,
    input  logic [NUM_CH-1:0]    req_wb,
    input  logic [NUM_CH*AW-1:0] req_base,
    input  logic [NUM_CH*AW-1:0] req_wb_base,
    input  logic [NUM_CH*8-1:0]  req_crit,
    output logic [AW-1:0]        ch_addr,
    output logic [DW-1:0]        ch_wdata,
    output logic [NUM_CH-1:0]    ch_we,
    input  logic [NUM_CH*DW-1:0] ch_rdata,
    output logic [NUM_CH-1:0]    ch_done,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [DW-1:0]        mem_rdata
);

    localparam int unsigned OW = $clog2(LINE_WORDS);
    localparam int unsigned CW = OW + 1;
    localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] LW_CNT = CW'(LINE_WORDS);

    typedef enum logic [1:0] {StIdle, StWb, StRd, StDone} state_t;

    state_t          state_q;
    logic [PW-1:0]   gnt_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [AW-1:0]   base_q;
    logic [AW-1:0]   wb_base_q;
    logic [OW-1:0]   crit_q;
    logic [CW-1:0]   wcnt_q;
    logic [CW-1:0]   iss_q;
    logic [CW-1:0]   ret_q;

    logic            any_req;
    logic [PW-1:0]   pick;
    logic [PW:0]     cand;
    logic [AW-1:0]   sel_base;
    logic [AW-1:0]   sel_wb_base;
    logic            sel_wb;
    logic [OW-1:0]   crit_sel;
    logic [NUM_CH-1:0] gnt_oh;
    logic            unused_crit;

    // Word n of a line: offset (c + n) wraps inside the line, address wraps mod 2^AW.
    function automatic logic [AW-1:0] line_addr(input logic [AW-1:0] b,
                                                input logic [OW-1:0] c,
                                                input logic [CW-1:0] n);
        logic [OW-1:0] off;
        off = c + n[OW-1:0];
        return b + AW'(off);
    endfunction

    // First requesting channel at or after rr_ptr_q, wrapping.
    always_comb begin
        any_req = 1'b0;
        pick    = rr_ptr_q;
        cand    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NUM_CH)) begin
                cand = cand - (PW+1)'(NUM_CH);
            end
            if (!any_req && req_change[cand[PW-1:0]]) begin
                any_req = 1'b1;
                pick    = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        sel_base    = req_base[pick*AW +: AW];
        sel_wb_base = req_wb_base[pick*AW +: AW];
        sel_wb      = req_wb[pick];
`ifdef CACHE_REFILL_CWF_EN
        crit_sel    = req_crit[pick*8 +: OW];
`else
        crit_sel    = '0;
`endif
    end

    assign unused_crit = ^req_crit;
    assign gnt_oh      = NUM_CH'(1) << gnt_q;

    // Write-back data comes straight from the cache, addressed by the registered ch_addr.
    always_comb begin
        mem_wdata = '0;
        if (state_q == StWb) begin
            mem_wdata = ch_rdata[gnt_q*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            rr_ptr_q  <= '0;
            base_q    <= '0;
            wb_base_q <= '0;
            crit_q    <= '0;
            wcnt_q    <= '0;
            iss_q     <= '0;
            ret_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            ch_addr   <= '0;
            ch_wdata  <= '0;
            ch_we     <= '0;
            ch_done   <= '0;
        end else begin
            ch_we   <= '0;
            ch_done <= '0;
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        gnt_q     <= pick;
                        base_q    <= sel_base;
                        wb_base_q <= sel_wb_base;
                        crit_q    <= crit_sel;
                        wcnt_q    <= '0;
                        iss_q     <= '0;
                        ret_q     <= '0;
                        mem_req   <= 1'b1;
                        if (sel_wb) begin
                            state_q  <= StWb;
                            mem_we   <= 1'b1;
                            mem_addr <= sel_wb_base;
                            ch_addr  <= sel_wb_base;
                        end else begin
                            state_q  <= StRd;
                            mem_we   <= 1'b0;
                            mem_addr <= line_addr(sel_base, crit_sel, '0);
                        end
                    end
                end
                StWb: begin
                    if (mem_gnt) begin
                        if (wcnt_q == LW_CNT - 1'b1) begin
                            state_q  <= StRd;
                            wcnt_q   <= '0;
                            mem_we   <= 1'b0;
                            mem_addr <= line_addr(base_q, crit_q, '0);
                        end else begin
                            wcnt_q   <= wcnt_q + 1'b1;
                            mem_addr <= wb_base_q + AW'(wcnt_q) + AW'(1);
                            ch_addr  <= wb_base_q + AW'(wcnt_q) + AW'(1);
                        end
                    end
                end
                StRd: begin
                    if (mem_req && mem_gnt) begin
                        if (iss_q == LW_CNT - 1'b1) begin
                            mem_req <= 1'b0;
                        end else begin
                            mem_addr <= line_addr(base_q, crit_q, iss_q + 1'b1);
                        end
                        iss_q <= iss_q + 1'b1;
                    end
                    // Leave RD only after the last registered ch_we pulse has been driven.
                    if (ret_q == LW_CNT) begin
                        state_q <= StDone;
                        ch_done <= gnt_oh;
                    end else if (mem_rvalid) begin
                        ch_we    <= gnt_oh;
                        ch_wdata <= mem_rdata;
                        ch_addr  <= line_addr(base_q, crit_q, ret_q);
                        ret_q    <= ret_q + 1'b1;
                    end
                end
                StDone: begin
                    rr_ptr_q <= (gnt_q == PW'(NUM_CH - 1)) ? '0 : gnt_q + 1'b1;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: in-order memory model with fixed latency,
// optional grant toggling and random read-return gaps.
module tb_cache_refill_ctrl;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LW  = 16;
    localparam int LAT = 2;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    req_change;
    logic [NCH-1:0]    req_wb;
    logic [NCH*AW-1:0] req_base;
    logic [NCH*AW-1:0] req_wb_base;
    logic [NCH*8-1:0]  req_crit;
    logic [AW-1:0]     ch_addr;
    logic [DW-1:0]     ch_wdata;
    logic [NCH-1:0]    ch_we;
    logic [NCH*DW-1:0] ch_rdata;
    logic [NCH-1:0]    ch_done;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DW-1:0]     mem_rdata;

    int cyc;
    int n_vec;
    int n_fail;
    int n_ret;
    int grant_cyc;
    bit gnt_toggle;
    bit gap_en;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] rd_addr[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] we_addr[$];
    logic [31:0] we_data[$];
    logic [1:0]  we_mask[$];
    logic [1:0]  done_mask[$];
    int          done_cyc[$];

    // Cache side: each channel's read data is its address xor a per-channel key.
    assign ch_rdata = {ch_addr ^ 32'h0BAD_0000, ch_addr ^ 32'hC0DE_0000};

    cache_refill_ctrl #(
        .NUM_CH    (NCH),
        .AW        (AW),
        .DW        (DW),
        .LINE_WORDS(LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_change (req_change),
        .req_wb     (req_wb),
        .req_base   (req_base),
        .req_wb_base(req_wb_base),
        .req_crit   (req_crit),
        .ch_addr    (ch_addr),
        .ch_wdata   (ch_wdata),
        .ch_we      (ch_we),
        .ch_rdata   (ch_rdata),
        .ch_done    (ch_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory model and monitors, evaluated mid-cycle.
    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_gnt    = gnt_toggle ? cyc[0] : 1'b1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
            end else begin
                if (pend_addr.size() > 0 && pend_due[0] <= cyc &&
                    !(gap_en && $urandom_range(0, 2) == 0)) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_addr[0] ^ 32'h0000_A5A5;
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                    n_ret++;
                end
                if (mem_req && mem_gnt) begin
                    if (mem_we) begin
                        wr_addr.push_back(mem_addr);
                        wr_data.push_back(mem_wdata);
                    end else begin
                        rd_addr.push_back(mem_addr);
                        pend_addr.push_back(mem_addr);
                        pend_due.push_back(cyc + LAT);
                    end
                end
                if (ch_we != '0) begin
                    we_mask.push_back(ch_we);
                    we_addr.push_back(ch_addr);
                    we_data.push_back(ch_wdata);
                end
                if (ch_done != '0) begin
                    done_mask.push_back(ch_done);
                    done_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_addr.delete();
        wr_addr.delete();
        wr_data.delete();
        we_addr.delete();
        we_data.delete();
        we_mask.delete();
        done_mask.delete();
        done_cyc.delete();
        n_ret = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] base, input bit wb,
                          input logic [31:0] wbb, input logic [7:0] crit);
        req_base[ch*AW +: AW]    = base;
        req_wb_base[ch*AW +: AW] = wbb;
        req_wb[ch]               = wb;
        req_crit[ch*8 +: 8]      = crit;
    endtask

    task automatic start_req(input int ch, input logic [31:0] base, input bit wb,
                             input logic [31:0] wbb, input logic [7:0] crit);
        @(posedge clk);
        #1;
        set_ch(ch, base, wb, wbb, crit);
        req_change[ch] = 1'b1;
        grant_cyc      = cyc;
    endtask

    // Returns in the cycle after the n-th ch_done pulse, or after the budget expires.
    task automatic wait_done(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (done_mask.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_done_cnt"}, done_mask.size(), n);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_mem_req"}, {31'b0, mem_req}, 32'h0);
        check({pfx, "_mem_we"}, {31'b0, mem_we}, 32'h0);
        check({pfx, "_mem_addr"}, mem_addr, 32'h0);
        check({pfx, "_mem_wdata"}, mem_wdata, 32'h0);
        check({pfx, "_ch_addr"}, ch_addr, 32'h0);
        check({pfx, "_ch_wdata"}, ch_wdata, 32'h0);
        check({pfx, "_ch_we"}, {30'b0, ch_we}, 32'h0);
        check({pfx, "_ch_done"}, {30'b0, ch_done}, 32'h0);
    endtask

    task automatic check_refill(input string tag, input logic [31:0] base, input int crit,
                                input logic [1:0] mask);
        logic [31:0] exp_a;
        int off;
        check({tag, "_rd_cnt"}, rd_addr.size(), LW);
        check({tag, "_we_cnt"}, we_addr.size(), LW);
        for (int n = 0; n < LW; n++) begin
`ifdef CACHE_REFILL_CWF_EN
            off = (crit + n) % LW;
`else
            off = n + (crit * 0);
`endif
            exp_a = base + 32'(off);
            check($sformatf("%s_rd_addr[%0d]", tag, n), rd_addr[n], exp_a);
            check($sformatf("%s_we_addr[%0d]", tag, n), we_addr[n], exp_a);
            check($sformatf("%s_we_data[%0d]", tag, n), we_data[n], exp_a ^ 32'h0000_A5A5);
            check($sformatf("%s_we_mask[%0d]", tag, n), {30'b0, we_mask[n]}, {30'b0, mask});
        end
    endtask

    initial begin
        n_vec      = 0;
        n_fail     = 0;
        n_ret      = 0;
        grant_cyc  = 0;
        gnt_toggle = 1'b0;
        gap_en     = 1'b0;
        rst        = 1'b1;
        req_change = '0;
        req_wb     = '0;
        req_base   = '0;
        req_wb_base = '0;
        req_crit   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");

        // Basic refill on ch0.
        idle(2);
        clear_logs();
        start_req(0, 32'h0000_0100, 1'b0, 32'h0, 8'd0);
        wait_done("basic", 1, 100);
        req_change[0] = 1'b0;
        check("basic_latency", done_cyc[0] - grant_cyc, 20);
        check("basic_done_mask", {30'b0, done_mask[0]}, 32'h1);
        check_refill("basic", 32'h0000_0100, 0, 2'b01);
        idle(5);

        // Write-back then refill on ch1.
        clear_logs();
        start_req(1, 32'h0000_0300, 1'b1, 32'h0000_0200, 8'd0);
        wait_done("wb", 1, 150);
        req_change[1] = 1'b0;
        req_wb[1]     = 1'b0;
        check("wb_wr_cnt", wr_addr.size(), LW);
        for (int n = 0; n < LW; n++) begin
            check($sformatf("wb_wr_addr[%0d]", n), wr_addr[n], 32'h200 + 32'(n));
            check($sformatf("wb_wr_data[%0d]", n), wr_data[n],
                  (32'h200 + 32'(n)) ^ 32'h0BAD_0000);
        end
        check("wb_latency", done_cyc[0] - grant_cyc, 36);
        check("wb_done_mask", {30'b0, done_mask[0]}, 32'h2);
        check_refill("wb", 32'h0000_0300, 0, 2'b10);
        idle(5);
        check("wb_single_done", done_mask.size(), 1);

        // Arbitration: both raised together, each dropped after its own done.
        clear_logs();
        @(posedge clk);
        #1;
        set_ch(0, 32'h0000_0600, 1'b0, 32'h0, 8'd0);
        set_ch(1, 32'h0000_0700, 1'b0, 32'h0, 8'd0);
        req_change = 2'b11;
        wait_done("arb1", 1, 100);
        req_change[0] = 1'b0;
        wait_done("arb2", 2, 100);
        req_change[1] = 1'b0;
        idle(5);
        check("arb_total", done_mask.size(), 2);
        check("arb_first", {30'b0, done_mask[0]}, 32'h1);
        check("arb_second", {30'b0, done_mask[1]}, 32'h2);

        // Both held across three transfers: service alternates.
        clear_logs();
        @(posedge clk);
        #1;
        req_change = 2'b11;
        wait_done("hold1", 1, 100);
        wait_done("hold2", 2, 100);
        wait_done("hold3", 3, 100);
        req_change = 2'b00;
        idle(5);
        check("hold_total", done_mask.size(), 3);
        check("hold_0", {30'b0, done_mask[0]}, 32'h1);
        check("hold_1", {30'b0, done_mask[1]}, 32'h2);
        check("hold_2", {30'b0, done_mask[2]}, 32'h1);
        check("hold_we_cnt", we_addr.size(), 3 * LW);

        // Backpressure: toggling grant and random return gaps.
        clear_logs();
        gnt_toggle = 1'b1;
        gap_en     = 1'b1;
        start_req(0, 32'h0000_0500, 1'b0, 32'h0, 8'd0);
        wait_done("bp", 1, 400);
        req_change[0] = 1'b0;
        idle(10);
        check_refill("bp", 32'h0000_0500, 0, 2'b01);
        check("bp_no_late_we", we_addr.size(), LW);
        gnt_toggle = 1'b0;
        gap_en     = 1'b0;

        // Reset after five returns aborts without ch_done.
        clear_logs();
        start_req(0, 32'hFFFF_FFF8, 1'b0, 32'h0, 8'd0);
        for (int k = 0; k < 100 && n_ret < 5; k++) begin
            @(posedge clk);
            #1;
        end
        check("rst_ret5", {31'b0, n_ret >= 5}, 32'h1);
        rst        = 1'b1;
        req_change = '0;
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        idle(30);
        check("midrst_no_done", done_mask.size(), 0);

        // Rerun wrapping past the top of the address space.
        clear_logs();
        start_req(0, 32'hFFFF_FFF8, 1'b0, 32'h0, 8'd0);
        wait_done("wrap", 1, 100);
        req_change[0] = 1'b0;
        check_refill("wrap", 32'hFFFF_FFF8, 0, 2'b01);
        idle(5);

        // Critical word 13 on ch1 (plain order when the feature is compiled out).
        clear_logs();
        start_req(1, 32'h0000_0400, 1'b0, 32'h0, 8'd13);
        wait_done("cwf", 1, 100);
        req_change[1] = 1'b0;
        check_refill("cwf", 32'h0000_0400, 13, 2'b10);
        req_crit = '0;
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Parametrised cache-line refill/write-back engine between NUM_CH CPU-side caches (instruction and data) and one shared backing-memory port.
- Generalises the existing per-cache change_cache / WB_cache / Done handshake to N channels, with round-robin arbitration.
- Supports a configurable line length and a pipelined memory port that allows multiple reads in flight.
- Sits outside the CPU core, in place of the per-cache memory-controller glue.

Parameters:
NUM_CH, 2, number of cache channels (1..8)
AW, 32, address width (word addresses)
DW, 32, data width
LINE_WORDS, 16, words per line; power of 2, 2..256

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_change  in  NUM_CH  per-channel level request: refill line at req_base
req_wb  in  NUM_CH  per-channel: write back dirty line at req_wb_base before refill
req_base  in  NUM_CH*AW  packed new-line base address; channel k at [k*AW +: AW]
req_wb_base  in  NUM_CH*AW  packed base address of the line being evicted
req_crit  in  NUM_CH*8  packed critical-word offset (used only with the optional feature)
ch_addr  out  AW  word address into the granted cache
ch_wdata  out  DW  refill data to the cache
ch_we  out  NUM_CH  one-hot cache write strobe
ch_rdata  in  NUM_CH*DW  cache read data; combinational from ch_addr, same cycle
ch_done  out  NUM_CH  one-cycle completion pulse
mem_req  out  1  memory command valid
mem_we  out  1  1 = write, 0 = read
mem_addr  out  AW  memory word address
mem_wdata  out  DW  memory write data
mem_gnt  in  1  command accepted this cycle (mem_req & mem_gnt)
mem_rvalid  in  1  read data valid; responses return in order
mem_rdata  in  DW  read data

Behaviour:
- Reset values:
  - All outputs 0; FSM = IDLE; counters = 0; round-robin pointer = 0.
  - A reset mid-transfer aborts the transfer with no ch_done pulse.
  - Any mem_rvalid arriving while in IDLE is discarded.
- FSM states: IDLE, WB, RD, DONE.
- IDLE:
  - If any req_change bit is set, grant the first set channel at or after rr_ptr, with wrap-around.
  - Latch g, req_base, req_wb_base, req_wb and req_crit for channel g.
  - Next state is WB if req_wb[g], else RD. Grant takes 1 cycle; no memory command is issued in IDLE.
- WB:
  - mem_req=1, mem_we=1, mem_addr = ch_addr = wb_base+i, mem_wdata = ch_rdata[g].
  - i increments on mem_gnt. After the LINE_WORDS-th accepted write, go to RD; i is reset for RD.
- RD, issue side:
  - mem_req=1, mem_we=0, mem_addr = base+iss. iss increments on mem_gnt.
  - mem_req drops once iss == LINE_WORDS.
- RD, return side:
  - Each mem_rvalid drives ch_we[g]=1, ch_wdata = mem_rdata, ch_addr = base+ret; then ret increments.
  - When ret reaches LINE_WORDS, go to DONE.
  - mem_gnt and mem_rvalid in the same cycle are both counted.
- DONE:
  - ch_done[g]=1 for exactly one cycle; rr_ptr = g+1 mod NUM_CH; next state IDLE.
  - The requester must deassert req_change by the cycle after ch_done. A request still high in that cycle is treated as a new request.
- Request changes during a transfer:
  - Deasserting req_change mid-transfer is ignored; the transfer completes.
  - Requests from other channels wait in IDLE.
- Address arithmetic is mod 2^AW, so a line may wrap past the top of the address space. Bases need not be line-aligned.
- Counters are $clog2(LINE_WORDS)+1 bits wide. ch_we is never asserted outside RD.
- Throughput: with mem_gnt held at 1 and fixed latency L, a refill completes in LINE_WORDS+L+2 cycles from the grant.

Optional Feature:
CACHE_REFILL_CWF_EN (critical-word-first):
- Defined:
  - The RD issue and write order starts at word c = req_crit[g] mod LINE_WORDS.
  - Offsets run c, c+1, ... and wrap within the line: offset (c+n) mod LINE_WORDS, added to base.
  - ch_addr follows the same order as mem_addr.
- Undefined: req_crit is ignored and the order is always offset 0..LINE_WORDS-1.
- WB order is unaffected in both cases.

Test Plan:
- Basic refill: ch0, base 0x100, LINE_WORDS=16, gnt=1, latency 2, mem_rdata = addr^0xA5A5 -> 16 ch_we[0] pulses at ch_addr 0x100..0x10F with matching data; ch_done[0] 20 cycles after grant.
- Write-back then refill: ch1, req_wb=1, wb_base 0x200, base 0x300 -> 16 mem writes to 0x200..0x20F carrying ch_rdata, then 16 reads from 0x300..0x30F; a single ch_done[1] pulse.
- Arbitration: ch0 and ch1 raised in the same cycle with rr_ptr=0 -> ch0 serviced first, then ch1; repeat with both held -> order alternates ch0, ch1, ch0 across 3 transfers.
- Backpressure: mem_gnt toggling 1,0,1,0 with random rvalid gaps -> exactly 16 commands issued; data is written in address order; no ch_we outside RD.
- Reset and wrap: base 0xFFFFFFF8, reset asserted after 5 returns -> all outputs 0 on the next cycle and no ch_done; rerun without reset -> ch_addr runs 0xFFFFFFF8..0xFFFFFFFF then 0x0..0x7.
- CWF (macro defined): base 0x400, crit=13 -> mem_addr/ch_addr order 0x40D, 0x40E, 0x40F, 0x400..0x40C; with the macro undefined the order is 0x400..0x40F.
